// File: rtl/led_seq_pkg.sv
// Shared mode codes, step-timer default and bounce direction type for the LED
// sequencer and any demo top that drives it.
package led_seq_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  // 50 ms per step at the 12 MHz board clock
  localparam int TICK_CNT_DEF = 600000;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running step timer: one-cycle tick every TICK_CNT cycles, frozen by hold
// and restarted from zero by clr (clr wins over hold and suppresses the tick).
module led_tick_gen
  import led_seq_pkg::*;
#(
  parameter int TICK_CNT = TICK_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(TICK_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CNT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CNT_LAST) && !hold && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: chase up/down, bounce and bar-graph fill with registered
// LED drive. Define LEDSEQ_BOUNCE_EN to build the bounce pattern; otherwise mode 2 chases up.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int TICK_CNT   = TICK_CNT_DEF,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic                         pause,
  output logic [N_LEDS-1:0]            leds,
  output logic [$clog2(N_LEDS+1)-1:0]  pos,
  output logic                         wrap
);

  localparam int PW = $clog2(N_LEDS + 1);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_FULL = PW'(N_LEDS);
  localparam logic [N_LEDS-1:0] LEDS_RST = (ACTIVE_LOW != 0) ? ~N_LEDS'(1) : N_LEDS'(1);

  logic [1:0]    mode_q;
  logic          restart;
  logic          tick;
  logic [PW-1:0] pos_nxt;
  logic          wrap_nxt;
`ifdef LEDSEQ_BOUNCE_EN
  dir_e          dir_q, dir_nxt;
`endif

  // Fill lights the low `p` bits; every other mode is one-hot at p.
  function automatic logic [N_LEDS-1:0] decode(input logic [1:0] m, input logic [PW-1:0] p);
    logic [N_LEDS-1:0] raw;
    for (int i = 0; i < N_LEDS; i++)
      raw[i] = (m == MODE_FILL) ? (i < int'(p)) : (i == int'(p));
    return (ACTIVE_LOW != 0) ? ~raw : raw;
  endfunction

  assign restart = (mode != mode_q);

  led_tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .hold  (pause),
    .tick  (tick)
  );

  always_comb begin
    pos_nxt  = pos;
    wrap_nxt = 1'b0;
`ifdef LEDSEQ_BOUNCE_EN
    dir_nxt  = dir_q;
`endif
    if (restart) begin
      pos_nxt = (mode == MODE_DOWN) ? POS_LAST : '0;
`ifdef LEDSEQ_BOUNCE_EN
      dir_nxt = DIR_UP;
`endif
    end else if (tick) begin
      case (mode_q)
        MODE_DOWN: begin
          pos_nxt  = (pos == '0) ? POS_LAST : pos - POS_ONE;
          wrap_nxt = (pos == '0);
        end
`ifdef LEDSEQ_BOUNCE_EN
        // Direction flips on arrival at an endpoint so neither end repeats.
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            pos_nxt = pos + POS_ONE;
            if (pos_nxt == POS_LAST) dir_nxt = DIR_DOWN;
          end else begin
            pos_nxt = pos - POS_ONE;
            if (pos_nxt == '0) begin
              dir_nxt  = DIR_UP;
              wrap_nxt = 1'b1;
            end
          end
        end
`endif
        MODE_FILL: begin
          pos_nxt  = (pos == POS_FULL) ? '0 : pos + POS_ONE;
          wrap_nxt = (pos == POS_FULL);
        end
        default: begin
          pos_nxt  = (pos == POS_LAST) ? '0 : pos + POS_ONE;
          wrap_nxt = (pos == POS_LAST);
        end
      endcase
    end
  end

  // The LED drive is decoded from the next position so it lands on the same edge as pos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_UP;
      pos    <= '0;
      wrap   <= 1'b0;
      leds   <= LEDS_RST;
    end else begin
      mode_q <= mode;
      pos    <= pos_nxt;
      wrap   <= wrap_nxt;
      leds   <= decode(mode, pos_nxt);
    end
  end

`ifdef LEDSEQ_BOUNCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= DIR_UP;
    else        dir_q <= dir_nxt;
  end
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: a 4-LED active-low instance and an 8-LED active-high
// instance share stimulus; directed table, bounce and reset sequences, then random traffic.
module tb_led_sequencer;
  import led_seq_pkg::*;

`ifdef LEDSEQ_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif
  localparam int T = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause;
  logic [1:0] mode;
  logic [3:0] leds4;
  logic [2:0] pos4;
  logic       wrap4;
  logic [7:0] leds8;
  logic [3:0] pos8;
  logic       wrap8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_sequencer #(.N_LEDS(4), .TICK_CNT(T), .ACTIVE_LOW(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause),
    .leds(leds4), .pos(pos4), .wrap(wrap4)
  );

  led_sequencer #(.N_LEDS(8), .TICK_CNT(T), .ACTIVE_LOW(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause),
    .leds(leds8), .pos(pos8), .wrap(wrap8)
  );

  // Reference: count ticks since the last restart, derive position from the pattern period.
  int m_mq[2];
  int m_ph[2];
  int m_k[2];
  bit m_w[2];

  function automatic int nled(int j);
    return (j == 0) ? 4 : 8;
  endfunction

  function automatic int eff(int m);
    return (m == 2 && !BOUNCE) ? 0 : m;
  endfunction

  function automatic int period(int m, int n);
    case (eff(m))
      0, 1:    return n;
      2:       return 2 * n - 2;
      default: return n + 1;
    endcase
  endfunction

  function automatic int mpos(int m, int k, int n);
    int p;
    case (eff(m))
      0: return k % n;
      1: return n - 1 - (k % n);
      2: begin
        p = k % (2 * n - 2);
        return (p < n) ? p : 2 * n - 2 - p;
      end
      default: return k % (n + 1);
    endcase
  endfunction

  function automatic logic [7:0] mleds(int m, int p, int n, bit al);
    logic [7:0] r = '0;
    for (int i = 0; i < n; i++)
      r[i] = (eff(m) == 3) ? (i < p) : (i == p);
    if (al) r = r ^ 8'((1 << n) - 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_mq[j] = 0; m_ph[j] = 0; m_k[j] = 0; m_w[j] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int j = 0; j < 2; j++) begin
      m_w[j] = 1'b0;
      if (int'(mode) != m_mq[j]) begin
        m_mq[j] = int'(mode); m_ph[j] = 0; m_k[j] = 0;
      end else if (!pause) begin
        if (m_ph[j] == T - 1) begin
          m_ph[j] = 0;
          m_k[j]++;
          m_w[j] = (m_k[j] % period(m_mq[j], nled(j))) == 0;
        end else begin
          m_ph[j]++;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_leds4", 32'(leds4), 32'(mleds(m_mq[0], mpos(m_mq[0], m_k[0], 4), 4, 1'b1)));
    chk("m_pos4",  32'(pos4),  32'(mpos(m_mq[0], m_k[0], 4)));
    chk("m_wrap4", 32'(wrap4), 32'(m_w[0]));
    chk("m_leds8", 32'(leds8), 32'(mleds(m_mq[1], mpos(m_mq[1], m_k[1], 8), 8, 1'b0)));
    chk("m_pos8",  32'(pos8),  32'(mpos(m_mq[1], m_k[1], 8)));
    chk("m_wrap8", 32'(wrap8), 32'(m_w[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       pause;
    int         n;
    logic [3:0] leds;
    logic [2:0] pos;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic [1:0] m, logic p, int n, logic [3:0] l, logic [2:0] ps, logic w);
    vec_t v;
    v.mode = m; v.pause = p; v.n = n; v.leds = l; v.pos = ps; v.wrap = w;
    tbl.push_back(v);
  endtask

  int bseq[7] = '{1, 2, 3, 2, 1, 0, 1};
  int useq[7] = '{1, 2, 3, 0, 1, 2, 3};

  initial begin
    logic [1:0] prev_mode;
    int exp_p;
    int wrap_idx;

    // Each row: hold inputs for n cycles, then check the 4-LED instance.
    add(0, 0, 2, 4'b1110, 0, 0);
    add(0, 0, 1, 4'b1101, 1, 0);
    add(0, 0, 3, 4'b1011, 2, 0);
    add(0, 0, 3, 4'b0111, 3, 0);
    add(0, 0, 2, 4'b0111, 3, 0);
    add(0, 0, 1, 4'b1110, 0, 1);
    add(0, 0, 1, 4'b1110, 0, 0);
    add(0, 0, 6, 4'b1011, 2, 0);
    add(0, 1, 10, 4'b1011, 2, 0);
    add(1, 1, 1, 4'b0111, 3, 0);
    add(1, 1, 4, 4'b0111, 3, 0);
    add(1, 0, 2, 4'b0111, 3, 0);
    add(1, 0, 1, 4'b1011, 2, 0);
    add(1, 0, 1, 4'b1011, 2, 0);
    add(1, 1, 10, 4'b1011, 2, 0);
    add(1, 0, 1, 4'b1011, 2, 0);
    add(1, 0, 1, 4'b1101, 1, 0);
    add(1, 0, 3, 4'b1110, 0, 0);
    add(1, 0, 2, 4'b1110, 0, 0);
    add(1, 0, 1, 4'b0111, 3, 1);
    add(1, 0, 2, 4'b0111, 3, 0);
    add(1, 1, 1, 4'b0111, 3, 0);
    add(1, 0, 1, 4'b1011, 2, 0);
    add(3, 0, 1, 4'b1111, 0, 0);
    add(3, 0, 3, 4'b1110, 1, 0);
    add(3, 0, 3, 4'b1100, 2, 0);
    add(3, 0, 3, 4'b1000, 3, 0);
    add(3, 0, 3, 4'b0000, 4, 0);
    add(3, 0, 2, 4'b0000, 4, 0);
    add(3, 0, 1, 4'b1111, 0, 1);

    rst_n = 1'b0; mode = MODE_UP; pause = 1'b0;
    model_reset();
    cyc();
    chk("rst_leds4", 32'(leds4), 32'h0E);
    chk("rst_pos4",  32'(pos4),  32'h0);
    chk("rst_wrap4", 32'(wrap4), 32'h0);
    chk("rst_leds8", 32'(leds8), 32'h01);
    rst_n = 1'b1;

    prev_mode = MODE_UP;
    for (int i = 0; i < tbl.size(); i++) begin
      mode = tbl[i].mode; pause = tbl[i].pause;
      for (int c = 0; c < tbl[i].n; c++) cyc();
      chk($sformatf("row%0d_leds", i), 32'(leds4), 32'(tbl[i].leds));
      chk($sformatf("row%0d_pos", i),  32'(pos4),  32'(tbl[i].pos));
      chk($sformatf("row%0d_wrap", i), 32'(wrap4), 32'(tbl[i].wrap));
      if (tbl[i].mode == MODE_DOWN && prev_mode != MODE_DOWN)
        chk("dut8_down_start", 32'(leds8), 32'h80);
      prev_mode = tbl[i].mode;
    end

    // Bounce (or chase up when bounce is not built): pos after every third cycle.
    mode = MODE_BOUNCE; pause = 1'b0;
    cyc();
    chk("b_start_pos", 32'(pos4), 32'h0);
    wrap_idx = BOUNCE ? 5 : 3;
    for (int i = 0; i < 7; i++) begin
      repeat (T) cyc();
      exp_p = BOUNCE ? bseq[i] : useq[i];
      chk($sformatf("b%0d_pos", i),  32'(pos4),  32'(exp_p));
      chk($sformatf("b%0d_wrap", i), 32'(wrap4), 32'(i == wrap_idx));
    end

    // Asynchronous reset mid-run, then first step three cycles after release.
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_leds4", 32'(leds4), 32'h0E);
    chk("arst_pos4",  32'(pos4),  32'h0);
    chk("arst_wrap4", 32'(wrap4), 32'h0);
    mode = MODE_UP;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("rel_pos_hold", 32'(pos4), 32'h0);
    cyc();
    chk("rel_first_step", 32'(pos4), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer for the STEPFPGA board's user LEDs. It drives N_LEDS outputs through one of four patterns: chase up, chase down, bounce, or bar-graph fill. Each step lasts a fixed number of clock cycles. It replaces the fixed 8-LED chaser and sits directly between the board clock and the LED pins, with a pause input and status outputs for higher-level demo logic.

## Interface
- N_LEDS, 8: number of LEDs driven; legal range 2..32.
- TICK_CNT, 600000: clock cycles per pattern step (50 ms at 12 MHz); must be ≥ 2.
- ACTIVE_LOW, 1: 1 means a lit LED is driven 0 (board LEDs are inverting); 0 means a lit LED is driven 1.
- clk  in  1  system clock (12 MHz on board).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- mode  in  2  pattern select: 0 chase up, 1 chase down, 2 bounce, 3 fill.
- pause  in  1  1 freezes the step timer and the pattern.
- leds  out  N_LEDS  registered LED drive, polarity per ACTIVE_LOW.
- pos  out  clog2(N_LEDS+1)  current lit index (chase modes) or fill level (fill mode).
- wrap  out  1  one-cycle pulse when a full pattern period completes.

## Operation
- Step timer: counter cnt runs 0..TICK_CNT-1.
  - Tick asserts for one cycle when cnt == TICK_CNT-1 and pause == 0.
  - cnt holds while pause == 1.
- mode is registered every cycle into mode_q. When mode != mode_q, a restart happens on that edge:
  - cnt clears and dir returns to up.
  - pos goes to the mode's start value: 0 for up, bounce and fill; N_LEDS-1 for down.
  - No tick or wrap is produced that cycle.
  - A restart overrides pause.
- Per-tick transitions:
  - Up: pos+1; on N_LEDS-1 → 0, wrap = 1.
  - Down: pos-1; on 0 → N_LEDS-1, wrap = 1.
  - Bounce: dir up increments to N_LEDS-1, then dir flips to down. Dir down decrements to 0, then dir flips to up and wrap = 1. Period is 2·N_LEDS-2 ticks, with no repeated endpoint.
  - Fill: level 0..N_LEDS, then N_LEDS → 0 with wrap = 1. Period is N_LEDS+1 ticks.
- Decode, before polarity is applied:
  - Chase modes: one-hot bit pos.
  - Fill: the low `level` bits are set, so level 0 means all LEDs off.
- leds is inverted when ACTIVE_LOW = 1.
- Width rule: pos is clog2(N_LEDS+1) bits so that the fill level N_LEDS is representable.
- All arithmetic is unsigned. No out-of-range pos value is reachable.

## Timing
- Reset values, asynchronous on rst_n low:
  - Counters and state: cnt = 0, pos = 0, dir = up, mode_q = 0.
  - Outputs: wrap = 0; leds = bit 0 lit (8'b11111110 for the defaults).
- leds, pos and wrap are all registered and update on the same edge as the tick. There is zero extra latency between pos and leds.
- First step after reset release or a restart occurs TICK_CNT cycles later.
- A mode change takes effect one edge after mode changes; leds reflects the new start pattern on that edge.
- When pause rises in the same cycle as a would-be tick, pause wins: no step.
- When pause falls, the timer resumes from the held cnt.
- wrap is exactly one cycle wide and never asserts while pause == 1.

## Configuration
- LEDSEQ_BOUNCE_EN
  - Defined: mode 2 is bounce as specified, and the dir register exists.
  - Undefined: mode 2 behaves identically to mode 0 (chase up), and the dir register and bounce logic are removed.

## Structure
- Package led_seq_pkg holds the following; the sequencer and any demo top import it.
  - Mode constants MODE_UP = 2'd0, MODE_DOWN = 2'd1, MODE_BOUNCE = 2'd2, MODE_FILL = 2'd3.
  - Default TICK_CNT.
- Sub-module led_tick_gen:
  - Parameter TICK_CNT; ports clk, rst_n, clr, hold, tick.
  - Holds the step counter and is reused by other timed demo blocks.

## Test plan
All scenarios use N_LEDS = 4, TICK_CNT = 3, ACTIVE_LOW = 1 unless stated.
- Reset: assert rst_n low mid-run → leds = 4'b1110, pos = 0, wrap = 0 immediately. First step 3 cycles after release.
- Chase up: mode 0 for 12 cycles → leds sequence 1110, 1101, 1011, 0111, 1110, with wrap pulsing on the 0111 → 1110 step.
- Bounce: mode 2 → pos sequence 0, 1, 2, 3, 2, 1, 0, with wrap only on the final 1 → 0 step, repeating every 6 ticks. Without LEDSEQ_BOUNCE_EN, mode 2 matches chase up.
- Fill: mode 3 → leds sequence 1111, 1110, 1100, 1000, 0000, 1111, with pos reaching 4 and wrap pulsing on the 4 → 0 step.
- Pause and mode change:
  - Pause held 10 cycles at pos 2 → no change and no wrap. On release, the step occurs after the remaining cnt.
  - Switching to mode 1 while paused → pos = 3 next edge and cnt cleared.
- ACTIVE_LOW = 0, N_LEDS = 8, chase down → leds starts 8'b10000000 one edge after mode is set. wrap pulses on the 0 → 7 step.
